// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared definitions for the GPIO port.
//   Register index constants for the 2-bit register address space and the
//   request/response handshake FSM state type.
package gpio_pkg;

  localparam logic [1:0] ADDR_DOUT = 2'd0;  // output data, read/write
  localparam logic [1:0] ADDR_DIN  = 2'd1;  // synchronized pins, read-only
  localparam logic [1:0] ADDR_EDGE = 2'd2;  // rising-edge status, write-1-to-clear
  localparam logic [1:0] ADDR_MASK = 2'd3;  // interrupt mask, read/write

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } gpio_state_t;

endpackage : gpio_pkg

// File: rtl/gpio_sync.sv
// gpio_sync -- multi-flop synchronizer for asynchronous pad inputs.
//   Parameters: WIDTH (bits), SYNC_STAGES (flop depth, must be >= 2).
//   Ports:
//     clk  in   clock, rising edge
//     rst  in   asynchronous active-low reset (all flops to 0)
//     d    in   WIDTH asynchronous inputs
//     q    out  WIDTH synchronized outputs
//     vld  out  high once q carries a sample taken after reset release
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0]       stage_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;

  // Stage chain: stage 0 samples the pad, the last stage feeds the core.
  // A 1 is shifted alongside the data so downstream logic can tell real
  // samples from the reset-zeroed contents of the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign q   = stage_q[SYNC_STAGES-1];
  assign vld = vld_q[SYNC_STAGES-1];

endmodule : gpio_sync

// File: rtl/gpio_port.sv
// gpio_port -- register-mapped GPIO block with a valid/ready request and
// response channel.
//   Optional feature macro: GPIO_PORT_IRQ_EN builds the EDGE/MASK registers
//   and the interrupt; without it addresses 2/3 read as 0, writes to them are
//   dropped (still acknowledged) and irq is tied low.
//   Parameters: WIDTH (pins per direction), SYNC_STAGES (synchronizer depth >= 2).
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-low reset
//     input_pins   in   WIDTH asynchronous pad inputs
//     output_pins  out  WIDTH registered pad outputs (DOUT)
//     req_valid    in   request present
//     req_ready    out  request accepted when high with req_valid
//     req_wr       in   1 = write, 0 = read
//     req_addr     in   register index (see gpio_pkg)
//     req_wdata    in   WIDTH write data
//     rsp_valid    out  response present
//     rsp_ready    in   response consumed when high with rsp_valid
//     rsp_rdata    out  WIDTH read data, 0 for write responses
//     irq          out  level interrupt, registered |(EDGE & MASK)
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_pins,
  output logic [WIDTH-1:0] output_pins,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [1:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             irq
);

  gpio_state_t      state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rsp_rdata_q;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (input_pins),
    .q   (din),
    .vld (din_vld)
  );

  // Handshake FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

`ifdef GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic             irq_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] w1c;

  // Only compare two real samples; the first sample after reset merely
  // primes prev_q, so pins already high at release do not flag an edge.
  assign rise = din & ~prev_q & {WIDTH{prev_vld_q}};
  assign w1c  = (accept && req_wr && (req_addr == ADDR_EDGE)) ? req_wdata : '0;

  // Edge detect / status / interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= din;
      prev_vld_q <= din_vld;
      // Clear first, then OR in new edges: a coincident edge survives.
      edge_q     <= (edge_q & ~w1c) | rise;
      if (accept && req_wr && (req_addr == ADDR_MASK)) begin
        mask_q <= req_wdata;
      end
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_din_vld;
  assign unused_din_vld = din_vld;
  assign irq            = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (req_addr)
      ADDR_DOUT: rd_mux = dout_q;
      ADDR_DIN:  rd_mux = din;
`ifdef GPIO_PORT_IRQ_EN
      ADDR_EDGE: rd_mux = edge_q;
      ADDR_MASK: rd_mux = mask_q;
`endif
      default:   rd_mux = '0;
    endcase
  end

  // Register write / response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q      <= '0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      if (req_wr && (req_addr == ADDR_DOUT)) begin
        dout_q <= req_wdata;
      end
      // Loaded only on accept, so it holds steady for the whole RESP phase.
      rsp_rdata_q <= req_wr ? '0 : rd_mux;
    end
  end

  assign output_pins = dout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule : gpio_port

// File: tb/tb_gpio_port.sv
// tb_gpio_port -- directed self-checking bench for gpio_port (WIDTH=8,
// SYNC_STAGES=2). Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge or 1 unit after the rising edge.
module tb_gpio_port;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] input_pins;
  logic [WIDTH-1:0] output_pins;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [1:0]       req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_port #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_pins  (input_pins),
    .output_pins (output_pins),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends 1 unit after a rising edge with the FSM idle; the
  // request is accepted on the single rising edge inside.
  task automatic issue(input logic wr, input logic [1:0] addr, input logic [WIDTH-1:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 2'd0;
    req_wdata = '0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [1:0] addr, input logic [WIDTH-1:0] wdata);
    issue(1'b1, addr, wdata);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    finish_rsp();
  endtask

  task automatic do_read(input string tag, input logic [1:0] addr, input logic [WIDTH-1:0] exp);
    issue(1'b0, addr, '0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check(tag, rsp_rdata, exp);
    finish_rsp();
  endtask

  initial begin
    rst        = 1'b0;
    input_pins = '0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = 2'd0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_output_pins", output_pins, 0);
    check("rst_irq", irq, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // DOUT write is on the pins right after the accepting edge
    issue(1'b1, 2'd0, 8'hA5);
    check("dout_pins_after_accept", output_pins, 8'hA5);
    check("dout_wr_req_ready", req_ready, 0);
    @(negedge clk);
    check("dout_wr_rsp_valid", rsp_valid, 1);
    check("dout_wr_rsp_rdata", rsp_rdata, 0);
    finish_rsp();
    check("dout_wr_back_idle", req_ready, 1);
    check("dout_wr_rsp_done", rsp_valid, 0);
    do_read("dout_read", 2'd0, 8'hA5);

    // DIN through the synchronizer; writes to DIN are dropped
    input_pins = 8'h3C;
    repeat (4) @(posedge clk);
    #1;
    do_read("din_read", 2'd1, 8'h3C);
    do_write("din_write", 2'd1, 8'hFF);
    do_read("din_read_after_wr", 2'd1, 8'h3C);
    check("din_wr_dout_kept", output_pins, 8'hA5);

    // Backpressure: response held, a second request is not taken
    issue(1'b0, 2'd0, '0);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 2'd0;
    req_wdata = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_req_ready_%0d", i), req_ready, 0);
      check($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 1);
      check($sformatf("bp_rsp_rdata_%0d", i), rsp_rdata, 8'hA5);
      check($sformatf("bp_pins_%0d", i), output_pins, 8'hA5);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_wdata = '0;
    finish_rsp();
    check("bp_back_idle", req_ready, 1);
    do_read("bp_dout_unchanged", 2'd0, 8'hA5);

`ifdef GPIO_PORT_IRQ_EN
    // Edges from 0x00 -> 0x3C are pending; mask is still 0
    do_read("edge_initial", 2'd2, 8'h3C);
    check("irq_masked", irq, 0);
    do_write("edge_clear_all", 2'd2, 8'hFF);
    do_read("edge_cleared", 2'd2, 8'h00);
    do_write("mask_wr", 2'd3, 8'h01);
    do_read("mask_read", 2'd3, 8'h01);

    // Bit0 rising edge raises irq through MASK
    input_pins = 8'h3D;
    repeat (5) @(posedge clk);
    #1;
    check("irq_bit0_set", irq, 1);
    do_read("edge_bit0", 2'd2, 8'h01);
    issue(1'b1, 2'd2, 8'h01);
    @(negedge clk);
    check("w1c_rsp_valid", rsp_valid, 1);
    finish_rsp();
    @(negedge clk);
    check("irq_cleared", irq, 0);
    @(posedge clk); #1;
    do_read("edge_after_w1c", 2'd2, 8'h00);

    // W1C of bit3 lands on the same edge that records a new bit3 edge
    input_pins = 8'h35;
    repeat (4) @(posedge clk);
    #1;
    do_read("edge_fall_ignored", 2'd2, 8'h00);
    input_pins = 8'h3D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(1'b1, 2'd2, 8'h08);
    @(negedge clk);
    check("w1c_edge_rsp_valid", rsp_valid, 1);
    finish_rsp();
    do_read("edge_wins_bit3", 2'd2, 8'h08);
    check("irq_bit3_unmasked", irq, 0);
`else
    // Feature disabled: EDGE/MASK absent, irq tied low
    do_write("edge_wr_noirq", 2'd2, 8'hFF);
    do_read("edge_read_noirq", 2'd2, 8'h00);
    do_write("mask_wr_noirq", 2'd3, 8'hFF);
    do_read("mask_read_noirq", 2'd3, 8'h00);
    input_pins = 8'h3D;
    repeat (5) @(posedge clk);
    #1;
    check("irq_tied_low", irq, 0);
    do_read("din_bit0", 2'd1, 8'h3D);
`endif

    // Reset in the middle of a response
    issue(1'b1, 2'd0, 8'h5A);
    @(negedge clk);
    check("mid_rsp_valid", rsp_valid, 1);
    check("mid_pins", output_pins, 8'h5A);
    rst = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_pins", output_pins, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_rsp_%0d", i), rsp_valid, 0);
      check($sformatf("post_rst_irq_%0d", i), irq, 0);
    end
    @(posedge clk); #1;
    do_read("post_rst_dout", 2'd0, 8'h00);
`ifdef GPIO_PORT_IRQ_EN
    // Pins were already high at release: no edge may be recorded
    do_read("post_rst_no_edge", 2'd2, 8'h00);
    do_read("post_rst_mask", 2'd3, 8'h00);
`endif
    do_read("post_rst_din", 2'd1, 8'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gpio_port

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the pin count per direction.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth (minimum 2).
REQ-003 SHALL have port clk  input  1  the single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port input_pins  input  WIDTH  asynchronous pad inputs.
REQ-006 SHALL have port output_pins  output  WIDTH  registered pad outputs.
REQ-007 SHALL have port req_valid  input  1  register access request.
REQ-008 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-009 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  2  register index.
REQ-011 SHALL have port req_wdata  input  WIDTH  write data.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  WIDTH  read data; 0 for write responses.
REQ-015 SHALL have port irq  output  1  level interrupt.

Function
REQ-016 SHALL implement registers: 0 DOUT (RW), 1 DIN (RO, synchronized pins), 2 EDGE (rising-edge status, write-1-to-clear), 3 MASK (RW).
REQ-017 SHALL drive output_pins directly from DOUT, so a write becomes visible on the pins the cycle after acceptance.
REQ-018 SHALL use a two-state FSM: IDLE (req_ready=1) and RESP (req_ready=0, rsp_valid=1).
REQ-019 SHALL move IDLE->RESP on req_valid&req_ready, and RESP->IDLE on rsp_ready; rsp_rdata SHALL stay stable while in RESP.
REQ-020 SHALL return read data captured in the accept cycle; the response is visible one cycle after acceptance.
REQ-021 SHALL generate one response per write as well as per read.
REQ-022 SHALL ignore writes to DIN; unused upper bits do not exist, because every register is exactly WIDTH bits wide.
REQ-023 SHALL set EDGE[i] when synced bit i goes 0->1 between consecutive cycles.
REQ-024 SHALL keep an EDGE bit set when a W1C of that bit and a new edge on it occur in the same cycle (edge wins).
REQ-025 SHALL drive irq as a registered |(EDGE & MASK), one cycle after the cause.
REQ-026 SHALL accept no edges during reset, and SHALL NOT flag the first sample after reset as an edge.

Reset
REQ-027 SHALL reset DOUT, EDGE, MASK and all synchronizer flops to 0.
REQ-028 SHALL reset the FSM to IDLE, req_ready to 1, rsp_valid to 0, rsp_rdata to 0 and irq to 0.
REQ-029 SHALL drop any pending response when reset asserts mid-transaction; no response is delivered after reset is removed.

Configuration
REQ-030 SHALL compile EDGE, MASK and irq logic only when GPIO_PORT_IRQ_EN is defined.
REQ-031 SHALL, without GPIO_PORT_IRQ_EN, read addresses 2 and 3 as 0, ignore writes to them (a response is still generated), and tie irq to 0.

Structure
REQ-032 SHALL take the register index constants (DOUT, DIN, EDGE, MASK) and the FSM state enum from shared package gpio_pkg.
REQ-033 SHALL implement the input synchronizer as sub-module gpio_sync, parameterized by WIDTH and SYNC_STAGES.

Verification
REQ-034 SHALL cover: write 0xA5 to DOUT -> output_pins=0xA5 one cycle after acceptance; read DOUT returns 0xA5.
REQ-035 SHALL cover: input_pins=0x3C held for 4 cycles, then read DIN -> rsp_rdata=0x3C.
REQ-036 SHALL cover: MASK=0x01, input_pins bit0 0->1 -> EDGE=0x01 and irq=1; write 0x01 to EDGE -> irq=0 within 2 cycles.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> req_ready=0 and rsp_rdata stable throughout; a second req_valid is not accepted.
REQ-038 SHALL cover: W1C of EDGE bit3 in the same cycle as a new bit3 edge -> EDGE bit3 remains 1.
REQ-039 SHALL cover: rst asserted while in RESP -> rsp_valid=0, output_pins=0x00 immediately; no response after release.
